// File: rtl/binary_search_param.sv
// binary_search_param: binary search over a sorted synchronous-read memory, exact-match or lower-bound mode
module binary_search_param #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 5,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  input  logic [DATA_WIDTH-1:0] A,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic [ADDR_WIDTH-1:0] I
);
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, COMPARE, DONE} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] a_r;
  logic mode_r, less, hit;
  logic [ADDR_WIDTH:0] lo, hi, mid, nlo, nhi;
  logic [2:0] cnt;
  // lo and hi carry one extra bit so hi can hold DEPTH
  always_comb begin
    mid = (lo + hi) >> 1;
    less = mem_data < a_r;
    hit = !mode_r && mem_data == a_r;
    nlo = less ? mid + (ADDR_WIDTH+1)'(1) : lo;
    nhi = less ? hi : mid;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      found <= 1'b0;
      I <= '0;
      mem_addr <= '0;
      lo <= '0;
      hi <= '0;
      cnt <= '0;
      a_r <= '0;
      mode_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_r <= A;
          mode_r <= mode;
          lo <= '0;
          hi <= DEPTH;
          done <= 1'b0;
          found <= 1'b0;
          busy <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: begin
          mem_addr <= mid[ADDR_WIDTH-1:0];
          cnt <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 3'd1;
          if (cnt == 3'(READ_LATENCY-1)) state <= COMPARE;
        end
        COMPARE: begin
          lo <= nlo;
          hi <= nhi;
          if (hit || nlo >= nhi) begin
            busy <= 1'b0;
            done <= 1'b1;
            found <= hit || (mode_r && nlo < DEPTH);
            I <= (hit || !mode_r) ? mid[ADDR_WIDTH-1:0] : nlo < DEPTH ? nlo[ADDR_WIDTH-1:0] : '1;
            state <= DONE;
          end else state <= ISSUE;
        end
        DONE: if (!start) begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_binary_search_param.sv
// tb_binary_search_param: scoreboard bench for two configurations of binary_search_param
module tb_binary_search_param;
  typedef struct {bit f; int idx; int s; int p;} exp_t;
  logic clk = 0, reset = 1;
  logic start0 = 0, mode0 = 0, busy0, done0, found0;
  logic [7:0] a0 = 0, md0;
  logic [4:0] addr0, i0;
  logic start1 = 0, mode1 = 0, busy1, done1, found1;
  logic [15:0] a1 = 0, md1;
  logic [7:0] addr1, i1;
  logic [15:0] p1 [3];
  int cyc = 0, n_tests = 0, n_fail = 0;
  exp_t q0[$], q1[$];

  binary_search_param dut0 (.clk(clk), .reset(reset), .start(start0), .mode(mode0), .A(a0),
    .mem_addr(addr0), .mem_data(md0), .busy(busy0), .done(done0), .found(found0), .I(i0));
  binary_search_param #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .READ_LATENCY(3)) dut1 (.clk(clk),
    .reset(reset), .start(start1), .mode(mode1), .A(a1), .mem_addr(addr1), .mem_data(md1),
    .busy(busy1), .done(done1), .found(found1), .I(i1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // memories: mem0[i]=2i with 1-cycle read, mem1[i]=3i with 3-cycle read
  always @(posedge clk) md0 <= 8'(2 * addr0);
  always @(posedge clk) begin
    p1[0] <= 16'(3 * addr1);
    p1[1] <= p1[0];
    p1[2] <= p1[1];
  end
  assign md1 = p1[2];

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // reference: sorted table mem[i]=mult*i; lower bound and exact hits by arithmetic,
  // probe count and the last probed index from a plain halving search
  function automatic void model(input int a, input bit m, input int depth, input int mult,
                                output bit f, output int idx, output int probes);
    int lo = 0, hi = depth, mid = 0, lb;
    probes = 0;
    while (lo < hi) begin
      mid = (lo + hi) / 2;
      probes++;
      if (!m && mid * mult == a) break;
      if (mid * mult < a) lo = mid + 1; else hi = mid;
    end
    lb = (a + mult - 1) / mult;
    if (m) begin
      f = lb < depth;
      idx = f ? lb : depth - 1;
    end else if (a % mult == 0 && a / mult < depth) begin
      f = 1;
      idx = a / mult;
    end else begin
      f = 0;
      idx = mid;
    end
  endfunction

  task automatic go0(input int a, input bit m);
    exp_t e;
    model(a, m, 32, 2, e.f, e.idx, e.p);
    @(negedge clk);
    start0 = 1; a0 = 8'(a); mode0 = m;
    e.s = cyc + 1;
    q0.push_back(e);
  endtask

  task automatic go1(input int a, input bit m);
    exp_t e;
    model(a, m, 256, 3, e.f, e.idx, e.p);
    @(negedge clk);
    start1 = 1; a1 = 16'(a); mode1 = m;
    e.s = cyc + 1;
    q1.push_back(e);
  endtask

  task automatic wait0();
    int k = 0;
    while (!done0 && k < 200) begin @(negedge clk); k++; end
    chk("done0_timeout", int'(done0), 1);
  endtask

  task automatic wait1();
    int k = 0;
    while (!done1 && k < 300) begin @(negedge clk); k++; end
    chk("done1_timeout", int'(done1), 1);
  endtask

  task automatic run0(input int a, input bit m);
    go0(a, m); wait0(); @(negedge clk); start0 = 0;
  endtask

  task automatic run1(input int a, input bit m);
    go1(a, m); wait1(); @(negedge clk); start1 = 0;
  endtask

  bit pd0 = 0, hp0 = 0, pd1 = 0, hp1 = 0;
  int lc0 = 0, lc1 = 0;
  logic [4:0] pa0 = 0;
  logic [7:0] pa1 = 0;

  always @(negedge clk) begin
    exp_t e;
    int lat;
    if (!reset) begin
      chk("busy_done_excl0", int'(busy0 && done0), 0);
      if (done0 && !pd0) begin
        if (q0.size() == 0) chk("unexpected_done0", 1, 0);
        else begin
          e = q0.pop_front();
          chk("found0", int'(found0), int'(e.f));
          chk("index0", int'(i0), e.idx);
          lat = cyc - e.s;
          chk("latency0_ok", int'(lat >= e.p * 3 && lat <= e.p * 3 + 1), 1);
        end
      end
      if (busy0 && addr0 != pa0) begin
        if (hp0) chk("probe_span0", cyc - lc0, 3);
        lc0 = cyc; hp0 = 1;
      end
    end
    if (!busy0) hp0 = 0;
    pd0 = done0; pa0 = addr0;
  end

  always @(negedge clk) begin
    exp_t e;
    int lat;
    if (!reset) begin
      chk("busy_done_excl1", int'(busy1 && done1), 0);
      if (done1 && !pd1) begin
        if (q1.size() == 0) chk("unexpected_done1", 1, 0);
        else begin
          e = q1.pop_front();
          chk("found1", int'(found1), int'(e.f));
          chk("index1", int'(i1), e.idx);
          lat = cyc - e.s;
          chk("latency1_ok", int'(lat >= e.p * 5 && lat <= e.p * 5 + 1), 1);
        end
      end
      if (busy1 && addr1 != pa1) begin
        if (hp1) chk("probe_span1", cyc - lc1, 5);
        lc1 = cyc; hp1 = 1;
      end
    end
    if (!busy1) hp1 = 0;
    pd1 = done1; pa1 = addr1;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] held;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_found", int'(found0), 0);
    chk("rst_index", int'(i0), 0);
    chk("rst_addr", int'(addr0), 0);
    reset = 0;
    run0(48, 0);
    run0(49, 0);
    run0(49, 1);
    run0(0, 1);
    run0(63, 1);
    run0(62, 0);
    // inputs changing mid-search must not affect the result
    go0(48, 0);
    repeat (3) @(negedge clk);
    a0 = 10; mode0 = 1;
    wait0();
    held = addr0;
    repeat (30) begin
      @(negedge clk);
      chk("hold_done", int'(done0), 1);
      chk("hold_busy", int'(busy0), 0);
      chk("hold_addr", int'(addr0), int'(held));
    end
    @(negedge clk); start0 = 0;
    run0(10, 0);
    // reset during the WAIT of the second probe
    go0(48, 0);
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk); reset = 1; start0 = 0;
    @(negedge clk);
    chk("midrst_busy", int'(busy0), 0);
    chk("midrst_done", int'(done0), 0);
    chk("midrst_addr", int'(addr0), 0);
    q0.delete();
    reset = 0;
    run0(20, 0);
    for (int k = 0; k < 40; k++) run0(int'($urandom_range(0, 70)), 1'($urandom_range(0, 1)));
    run1(300, 0);
    run1(300, 1);
    run1(766, 1);
    run1(0, 0);
    for (int k = 0; k < 15; k++) run1(int'($urandom_range(0, 800)), 1'($urandom_range(0, 1)));
    repeat (4) @(negedge clk);
    chk("sb0_empty", q0.size(), 0);
    chk("sb1_empty", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/binary_search_param.md
# binary_search_param

Parametrised successor to the board-level binary search engine. Searches a sorted, ascending, synchronous-read memory of 2^ADDR_WIDTH words of DATA_WIDTH bits for a key A, in either exact-match or lower-bound mode.

- Memory read latency is configurable, so the block works with the 32x8 RAM IP and with deeper or wider memories.
- Sits between the input filters/switch logic and the memory. Its index output drives the seg7 displays as before.

## Interface
Parameters:
- DATA_WIDTH, default 8: memory word and key width.
- ADDR_WIDTH, default 5: address width; DEPTH = 2^ADDR_WIDTH.
- READ_LATENCY, default 1 (legal range 1..4): number of clock edges from the memory capturing mem_addr to mem_data being valid.

Ports:
- clk  in  1  single system clock.
- reset  in  1  synchronous, active-high.
- start  in  1  level request. Sampled in IDLE only.
- mode  in  1  0 = exact match, 1 = lower bound (first index with mem >= A).
- A  in  DATA_WIDTH  search key. Captured when start is accepted.
- mem_addr  out  ADDR_WIDTH  registered memory address.
- mem_data  in  DATA_WIDTH  memory read data.
- busy  out  1  high from the accepted start until done asserts.
- done  out  1  result valid. Held until start deasserts.
- found  out  1  result flag (see Operation). Valid while done is high.
- I  out  ADDR_WIDTH  result index. Valid while done is high.

## Operation
- Search window is half-open [lo, hi). lo and hi are ADDR_WIDTH+1 bits wide so that hi can hold DEPTH without overflow.
- mid = (lo + hi) >> 1, computed at ADDR_WIDTH+1 bits and truncated to ADDR_WIDTH for the address.
- States:
  - IDLE: if start=1, capture A and mode into internal registers, set lo=0, hi=DEPTH, clear done/found, set busy=1, go to ISSUE.
  - ISSUE: mem_addr <= mid. Go to WAIT.
  - WAIT: hold for READ_LATENCY cycles, counted by an internal counter. Go to COMPARE.
  - COMPARE: compare mem_data with the captured A, unsigned.
    - Exact mode, mem_data == A: found=1, I=mid, go to DONE.
    - mem_data < A (either mode): next lo = mid+1.
    - Otherwise: next hi = mid.
    - If next lo >= next hi: go to DONE. Otherwise go to ISSUE.
  - DONE: busy=0, done=1. When start=0, clear done and go to IDLE. found and I keep their values until the next accepted start.
- Result when the window empties:
  - Exact mode: found=0; I = the last mid probed.
  - Lower-bound mode with lo < DEPTH: found=1, I=lo.
  - Lower-bound mode with lo == DEPTH: found=0, I=DEPTH-1 (the key exceeds every entry).
- Changes to A, mode or start while busy are ignored. start held high after done does not restart a search. A new search requires start to go low, then high again.
- Reset, including mid-search, returns to IDLE next edge. Reset values: busy=0, done=0, found=0, I=0, mem_addr=0, lo=0, hi=0. Any in-flight read is discarded.

## Timing
- Start acceptance: one cycle (IDLE → ISSUE).
- Each probe takes exactly READ_LATENCY+2 cycles: ISSUE 1, WAIT READ_LATENCY, COMPARE 1.
- mem_addr changes only on the edge leaving ISSUE. It is stable through WAIT and COMPARE.
- Probe count is at most ADDR_WIDTH+1. Worst case, done asserts 1 + (ADDR_WIDTH+1)·(READ_LATENCY+2) cycles after the start-sampling edge: 19 cycles at the defaults.
- done, found and I are registered. They update on the same edge, leaving COMPARE.
- busy and done are never high simultaneously. Exactly one of them is high from the acceptance edge until start deasserts.

## Test plan
Bench memory model: mem[i] = 2·i for ADDR_WIDTH=5 (values 0..62), with latency matching READ_LATENCY.
- Exact, A=48, default parameters → done=1, found=1, I=24, within 19 cycles. busy is low on the same edge that done rises.
- Exact, A=49 → found=0, done=1. Same inputs in lower-bound mode → found=1, I=25. Lower bound with A=0 → found=1, I=0.
- Lower bound, A=63 → found=0, I=31. Exact, A=62 → found=1, I=31 (upper boundary).
- Toggle A from 48 to 10 mid-search → result is still I=24. Hold start high for 30 cycles after done → no new probe, done stays 1. Drop start, then raise it with A=10 → I=5.
- Assert reset during WAIT of the second probe → next edge: busy=0, done=0, mem_addr=0. Release reset, then start with A=20 → I=10.
- READ_LATENCY=3, DATA_WIDTH=16, ADDR_WIDTH=8, mem[i]=3·i, A=300 → found=1, I=100. Every probe spans exactly 5 cycles.
